// File: rtl/mips_mc_ctrl.sv
// Multicycle controller for the simplified MIPS core.
// Fetches a 32-bit instruction over a MEMWIDTH-bit bus in BEATS slices, using a
// memready wait-state handshake. It then sequences the datapath for LB, SB,
// R-type, BEQ, BNE, ADDI and J. Any other opcode traps, and only reset leaves
// the trap state.
module mips_mc_ctrl #(
  parameter  int MEMWIDTH = 8,
  localparam int BEATS    = 32 / MEMWIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             memready,
  output logic             memread,
  output logic             memwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [2:0]       alucontrol,
  output logic [1:0]       pcsrc,
  output logic             pcen,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic             regwrite,
  output logic [BEATS-1:0] irwrite,
  output logic             illegal
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LASTBEAT = BW'(BEATS - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_LBRD, S_LBWR, S_SBWR, S_RTYPEEX,
    S_RTYPEWR, S_BEQEX, S_BNEEX, S_ADDIEX, S_ADDIWR, S_JEX, S_TRAP
  } state_t;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT} aluop_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            illegal_q, illegal_d;
  aluop_t          aluop;
  logic            pcwrite;
  logic            branch;
  logic            isbne;

  // State, fetch beat and sticky trap flag; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      beat_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic: memory states only advance once memready is seen.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: begin
        if (memready) begin
          if (beat_q == LASTBEAT) begin
            state_d = S_DECODE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      S_DECODE: begin
        case (op)
          OP_LB, OP_SB: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_BNE:       state_d = S_BNEEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SB) ? S_SBWR : S_LBRD;
      S_LBRD:    if (memready) state_d = S_LBWR;
      S_LBWR:    state_d = S_FETCH;
      S_SBWR:    if (memready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWR;
      S_RTYPEWR: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_BNEEX:   state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWR;
      S_ADDIWR:  state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_FETCH;
    endcase
  end

  // Datapath controls decoded straight from the current state; fetch enables held off during reset.
  always_comb begin
    memread  = 1'b0;
    memwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = ALU_ADD;
    pcsrc    = 2'b00;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    regwrite = 1'b0;
    irwrite  = '0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    isbne    = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        if (memready && reset) begin
          irwrite = BEATS'(1) << beat_q;
          pcwrite = 1'b1;
        end
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_LBRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_LBWR: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_SBWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALU_FUNCT;
      end
      S_RTYPEWR: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca = 1'b1;
        aluop   = ALU_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        isbne   = (state_q == S_BNEEX);
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWR: regwrite = 1'b1;
      S_JEX: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
      default: ;
    endcase
  end

  // ALU operation select; R-type uses the funct field, with 101 flagging an unknown funct.
  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      ALU_ADD: alucontrol = 3'b010;
      ALU_SUB: alucontrol = 3'b110;
      default: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b101;
        endcase
      end
    endcase
  end

  assign pcen    = pcwrite | (branch & (zero ^ isbne));
  assign illegal = illegal_q;

endmodule
